// File: rtl/fir_root_if.sv
// rtl/fir_root_if.sv - sample/coefficient/result bundle for fir_root
//
// Signals (DATA_W bits each):
//   Data_i    sample stream into the filter
//   B0..B6    quasi-static tap coefficients
//   FIRout    registered upper byte of the clamped filter sum
//   ROOTout   registered floor(sqrt) of the clamped filter sum
// Modports:
//   master    drives samples and coefficients, observes results
//   slave     the filter side
interface fir_root_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data_i;
    logic [DATA_W-1:0] B0;
    logic [DATA_W-1:0] B1;
    logic [DATA_W-1:0] B2;
    logic [DATA_W-1:0] B3;
    logic [DATA_W-1:0] B4;
    logic [DATA_W-1:0] B5;
    logic [DATA_W-1:0] B6;
    logic [DATA_W-1:0] FIRout;
    logic [DATA_W-1:0] ROOTout;

    modport master (
        output Data_i, B0, B1, B2, B3, B4, B5, B6,
        input  FIRout, ROOTout
    );

    modport slave (
        input  Data_i, B0, B1, B2, B3, B4, B5, B6,
        output FIRout, ROOTout
    );
endinterface

// File: rtl/fir_root.sv
// rtl/fir_root.sv - 7-tap FIR filter followed by a pipelined integer square root
//
// Ports:
//   Clk     rising-edge clock
//   Rst_n   synchronous reset, active HIGH despite the name
//   bus     fir_root_if.slave: Data_i, B0..B6 in; FIRout, ROOTout out
// Latency: FIRout one edge after a sample enters the delay line,
//          ROOTout eight edges after FIRout for the same sum.
// Build option: define FIRROOT_SAT_EN to saturate the sum at 2^(2*DATA_W)-1;
//               without it the sum wraps modulo 2^(2*DATA_W).
module fir_root #(
    parameter int DATA_W = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    fir_root_if.slave  bus
);
    localparam int TAPS = 7;
    localparam int C_W  = 2 * DATA_W;
    // Remainder never exceeds 2*root, so DATA_W+1 bits hold it; two more
    // bits leave room for the next radicand digit pair shifted in.
    localparam int RW   = DATA_W + 3;
`ifdef FIRROOT_SAT_EN
    localparam int SUM_W = C_W + 3;
`else
    // Wrap-around build only needs the low bits; truncating every partial
    // sum gives the same result as truncating the full sum.
    localparam int SUM_W = C_W;
`endif

    logic [DATA_W-1:0] coef [TAPS];
    logic [DATA_W-1:0] x_q  [TAPS];
    logic [SUM_W-1:0]  sum;
    logic [C_W-1:0]    c_next;
    logic [C_W-1:0]    c_q;

    assign coef[0] = bus.B0;
    assign coef[1] = bus.B1;
    assign coef[2] = bus.B2;
    assign coef[3] = bus.B3;
    assign coef[4] = bus.B4;
    assign coef[5] = bus.B5;
    assign coef[6] = bus.B6;

    // Sum works on the taps already in the delay line, so the result of a
    // sample loaded at edge t is registered at edge t+1.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + SUM_W'(x_q[k]) * SUM_W'(coef[k]);
        end
    end

`ifdef FIRROOT_SAT_EN
    always_comb begin
        c_next = sum[C_W-1:0];
        if (sum > SUM_W'({C_W{1'b1}})) begin
            c_next = '1;
        end
    end
`else
    assign c_next = sum;
`endif

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            c_q <= '0;
        end else begin
            x_q[0] <= bus.Data_i;
            for (int k = 1; k < TAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
            c_q <= c_next;
        end
    end

    // One restoring square-root digit: bring down the next two radicand
    // bits, try subtracting 4*root+1, keep the result bit if it fits.
    function automatic void sqrt_step(
        input  logic [C_W-1:0]    rad_in,
        input  logic [RW-1:0]     rem_in,
        input  logic [DATA_W-1:0] root_in,
        output logic [C_W-1:0]    rad_out,
        output logic [RW-1:0]     rem_out,
        output logic [DATA_W-1:0] root_out
    );
        logic [RW-1:0] cur;
        logic [RW-1:0] trial;
        cur   = (rem_in << 2) | RW'(rad_in[C_W-1 -: 2]);
        trial = (RW'(root_in) << 2) | RW'(1);
        if (cur >= trial) begin
            rem_out  = cur - trial;
            root_out = (root_in << 1) | DATA_W'(1);
        end else begin
            rem_out  = cur;
            root_out = root_in << 1;
        end
        rad_out = rad_in << 2;
    endfunction

    logic [C_W-1:0]    rad_nx  [DATA_W];
    logic [RW-1:0]     rem_nx  [DATA_W];
    logic [DATA_W-1:0] root_nx [DATA_W];
    logic [C_W-1:0]    rad_q   [DATA_W];
    logic [RW-1:0]     rem_q   [DATA_W];
    logic [DATA_W-1:0] root_q  [DATA_W];

    always_comb begin
        for (int s = 0; s < DATA_W; s++) begin
            rad_nx[s]  = '0;
            rem_nx[s]  = '0;
            root_nx[s] = '0;
        end
        sqrt_step(c_q, '0, '0, rad_nx[0], rem_nx[0], root_nx[0]);
        for (int s = 1; s < DATA_W; s++) begin
            sqrt_step(rad_q[s-1], rem_q[s-1], root_q[s-1],
                      rad_nx[s], rem_nx[s], root_nx[s]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            for (int s = 0; s < DATA_W; s++) begin
                rad_q[s]  <= '0;
                rem_q[s]  <= '0;
                root_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DATA_W; s++) begin
                rad_q[s]  <= rad_nx[s];
                rem_q[s]  <= rem_nx[s];
                root_q[s] <= root_nx[s];
            end
        end
    end

    assign bus.FIRout  = c_q[C_W-1 -: DATA_W];
    assign bus.ROOTout = root_q[DATA_W-1];
endmodule

// File: tb/tb_fir_root.sv
// tb/tb_fir_root.sv - directed self-checking bench for fir_root
module tb_fir_root;
    localparam int DATA_W = 8;
    localparam int LOG_N  = 512;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   errors;
    int   n;
    int   fir_log  [LOG_N];
    int   root_log [LOG_N];

    fir_root_if #(.DATA_W(DATA_W)) bus ();

    fir_root #(.DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and log the outputs it produced at index n-1.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (n < LOG_N) begin
            fir_log[n]  = int'(bus.FIRout);
            root_log[n] = int'(bus.ROOTout);
        end
        n++;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3,
                             input int c4, input int c5, input int c6);
        bus.B0 = 8'(c0); bus.B1 = 8'(c1); bus.B2 = 8'(c2); bus.B3 = 8'(c3);
        bus.B4 = 8'(c4); bus.B5 = 8'(c5); bus.B6 = 8'(c6);
    endtask

    task automatic do_reset();
        Rst_n = 1'b1;
        bus.Data_i = '0;
        tick();
        tick();
        Rst_n = 1'b0;
    endtask

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    int imp_fir  [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    int imp_root [8] = '{15, 22, 27, 31, 35, 39, 42, 0};
    int t;
    int exp_fir_ovf;
    int exp_root_ovf;

    initial begin
        checks = 0;
        errors = 0;
        n      = 0;
        Rst_n  = 1'b1;
        bus.Data_i = '0;
        set_coefs(1, 2, 3, 4, 5, 6, 7);

        // Reset with random samples present
        for (int i = 0; i < 2; i++) begin
            bus.Data_i = 8'($urandom_range(255));
            tick();
            check_eq("reset_fir", fir_log[n-1], 0);
            check_eq("reset_root", root_log[n-1], 0);
        end
        Rst_n = 1'b0;
        bus.Data_i = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("idle_fir", fir_log[n-1], 0);
            check_eq("idle_root", root_log[n-1], 0);
        end

        // Impulse response
        do_reset();
        set_coefs(1, 2, 3, 4, 5, 6, 7);
        bus.Data_i = 8'd255;
        tick();
        t = n - 1;
        bus.Data_i = '0;
        for (int i = 0; i < 18; i++) tick();
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("imp_fir[%0d]", k), fir_log[t+1+k], imp_fir[k]);
            check_eq($sformatf("imp_root[%0d]", k), root_log[t+9+k], imp_root[k]);
        end

        // Reset three edges after the impulse flushes the pipeline
        do_reset();
        bus.Data_i = 8'd255;
        tick();
        bus.Data_i = '0;
        tick();
        check_eq("mid_fir_t1", fir_log[n-1], 0);
        tick();
        check_eq("mid_fir_t2", fir_log[n-1], 1);
        Rst_n = 1'b1;
        tick();
        check_eq("mid_rst_fir", fir_log[n-1], 0);
        check_eq("mid_rst_root", root_log[n-1], 0);
        Rst_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("post_rst_fir", fir_log[n-1], 0);
            check_eq("post_rst_root", root_log[n-1], 0);
        end

        // Two active taps, DC input: 10*100 + 10*100 = 2000
        do_reset();
        set_coefs(10, 10, 0, 0, 0, 0, 0);
        bus.Data_i = 8'd100;
        for (int i = 0; i < 12; i++) tick();
        check_eq("dc_fir", fir_log[n-1], 7);
        check_eq("dc_root", root_log[n-1], 44);

        // Overflow: 7*255*255 = 455175
`ifdef FIRROOT_SAT_EN
        exp_fir_ovf  = 255;
        exp_root_ovf = 255;
`else
        exp_fir_ovf  = 242;
        exp_root_ovf = 248;
`endif
        do_reset();
        set_coefs(255, 255, 255, 255, 255, 255, 255);
        bus.Data_i = 8'd255;
        for (int i = 0; i < 20; i++) tick();
        check_eq("ovf_fir", fir_log[n-1], exp_fir_ovf);
        check_eq("ovf_root", root_log[n-1], exp_root_ovf);

        // Ramp through B0 only: every edge yields a fresh root
        do_reset();
        set_coefs(1, 0, 0, 0, 0, 0, 0);
        t = n;
        for (int i = 0; i < 20; i++) begin
            bus.Data_i = 8'(i);
            tick();
        end
        bus.Data_i = '0;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 20; i++) begin
            check_eq($sformatf("ramp_fir[%0d]", i), fir_log[t+1+i], 0);
            check_eq($sformatf("ramp_root[%0d]", i), root_log[t+9+i], isqrt(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_root.md
Name: fir_root

Overview:
- 7-tap direct-form FIR filter on an 8-bit unsigned sample stream, with programmable 8-bit unsigned coefficients.
- Followed by a pipelined integer square-root of the filter result.
- Sits in the signal-processing datapath. Both outputs are registered: FIRout is the scaled filter output, ROOTout is the magnitude-compressed (square-root) output.

Parameters:
- DATA_W, 8, width of Data_i, B0..B6, FIRout and ROOTout.
  - Accumulator is clamped/truncated to 2*DATA_W bits.
  - The root pipeline has DATA_W stages.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous reset, active-high: Rst_n=1 at a rising Clk edge resets the block.
- Data_i  input  DATA_W  unsigned input sample, captured every rising Clk edge.
- B0..B6  input  DATA_W each  unsigned tap coefficients. Quasi-static; used unregistered.
- FIRout  output  DATA_W  registered filter output, upper byte of the clamped sum.
- ROOTout  output  DATA_W  registered floor(sqrt) of the clamped sum.

Behaviour:
- Reset, when Rst_n=1 at a posedge:
  - Tap delay line x0..x6 cleared to 0.
  - FIR sum register cleared to 0.
  - All root-pipeline stage registers cleared to 0.
  - FIRout=0, ROOTout=0.
  - Reset has priority over all other activity; asserting it mid-stream flushes everything.
- Sample path, each posedge with no reset:
  - x0<=Data_i, and xk<=x(k-1) for k=1..6.
  - One sample is accepted per clock; there is no handshake and no stall.
- Sum:
  - S = B0*x0 + B1*x1 + ... + B6*x6, computed on the tap values just loaded.
  - Products are 2*DATA_W bits; the full sum is 2*DATA_W+3 bits with no intermediate overflow.
- Clamp:
  - C = min(S, 2^(2*DATA_W)-1), i.e. 16 bits.
  - C is registered one edge after the sample enters x0.
- FIRout = C[15:8]:
  - Valid one edge after the corresponding sample is captured (latency 1).
  - Result after x0 is loaded at edge t appears at edge t+1.
- ROOTout = floor(sqrt(C)), range 0..255:
  - Computed by an 8-stage pipelined restoring digit-by-digit square root, one result bit per stage.
  - Initiation interval is 1.
  - ROOTout corresponds to the same C as FIRout, appearing 8 edges later (edge t+9).
- Coefficient changes take effect on the next computed sum; there is no glitch protection.
- Unknown Data_i before the first valid sample is not filtered; outputs are don't-care until 7 valid samples have passed.

Optional Feature:
- Macro FIRROOT_SAT_EN.
- Defined: clamp as above. Sums above 65535 give FIRout=255 and ROOTout=255.
- Undefined: no clamp. C = S[15:0] (wrap-around, mod 65536); FIRout and ROOTout derive from the wrapped value.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold Rst_n=1 for 2 clocks with random Data_i -> FIRout=0 and ROOTout=0 at each edge. After release with Data_i=0, both outputs stay 0.
- Impulse response: B0..B6=1,2,3,4,5,6,7; Data_i=255 for one clock, then 0.
  - FIRout sequence from edge t+1: 0,1,2,3,4,5,6, then 0.
  - ROOTout sequence from edge t+9: 15,22,27,31,35,39,42, then 0.
- Partial taps DC: B0=B1=10, B2..B6=0; Data_i=100 constant -> steady state after 2 samples: FIRout=7 (sum 2000), ROOTout=44.
- Overflow: all B=255, Data_i=255 constant, after 7 samples.
  - FIRROOT_SAT_EN defined: FIRout=255, ROOTout=255.
  - Undefined: sum 455175 wraps to 61959, so FIRout=242, ROOTout=248.
- Reset mid-operation: run the impulse test and assert Rst_n for one clock 3 edges after the impulse -> next edge FIRout=0 and ROOTout=0. All later outputs stay 0 with Data_i=0; no stale pipeline values emerge.
- Throughput/latency: Data_i ramp 0..19, B0=1, others 0.
  - FIRout[t+1] = Data_i[t]>>8 = 0.
  - ROOTout[t+9] = floor(sqrt(Data_i[t])): 0,1,1,1,2,2,2,2,2,3,...
  - A new value appears every clock.
